psum_collector: RTL and testbench

//  Receiving end of the MAC array psum bus. Accumulates NUM_PASSES consecutive MAC_NUM x 6-bit psum vectors
//  (one vector per input-channel group) into per-lane accumulators, then optionally binarizes against a threshold.

---
 rtl/psum_collector.sv | 149 ++++++++++++++
 tb/tb_psum_collector.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_collector.sv
// Psum collector: sums NUM_PASSES psum vectors per lane into saturating accumulators,
// then streams the lanes (raw or thresholded to one bit) out over AXI-Stream.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start; accumulators hold the last tile
// S_ACCUM | accepting psum vectors, one per input-channel group
// S_DRAIN | streaming BEAT_LANES lanes per beat, tlast on the final beat
module psum_collector #(
  parameter int MAC_NUM    = 256,
  parameter int PSUM_W     = 6,
  parameter int ACC_W      = 12,
  parameter int BEAT_LANES = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [7:0]                  num_passes,
  input  logic                        binarize,
  input  logic [ACC_W-1:0]            threshold,
  input  logic [PSUM_W*MAC_NUM-1:0]   psum_in,
  input  logic                        psum_valid,
  output logic                        psum_ready,
  output logic [ACC_W*BEAT_LANES-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  output logic                        busy,
  output logic                        done
);

  localparam int NUM_BEATS = MAC_NUM / BEAT_LANES;
  localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int LANE_W    = (MAC_NUM > 1) ? $clog2(MAC_NUM) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);
  localparam logic [ACC_W-1:0]  ACC_MAX   = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [7:0]        npass;
  logic [7:0]        pass_cnt;
  logic              bin_q;
  logic [ACC_W-1:0]  thr_q;
  logic [BEAT_W-1:0] beat_idx;
  logic [ACC_W-1:0]  acc     [MAC_NUM];
  logic [ACC_W-1:0]  acc_sat [MAC_NUM];

  logic accept;
  logic beat_hs;
  logic last_pass;
  logic last_beat;
  logic clear;
  logic done_nx;
  logic [LANE_W-1:0] lane;

  assign accept    = psum_valid & psum_ready;
  assign beat_hs   = m_axis_tvalid & m_axis_tready;
  assign last_pass = (pass_cnt == (npass - 8'd1));
  assign last_beat = (beat_idx == LAST_BEAT);
  assign clear     = (state == S_IDLE) & start;
  assign busy      = (state != S_IDLE);
  assign m_axis_tlast = m_axis_tvalid & last_beat;

  always_comb begin
    state_nx      = state;
    psum_ready    = 1'b0;
    m_axis_tvalid = 1'b0;
    done_nx       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_ACCUM;
      end
      S_ACCUM: begin
        psum_ready = 1'b1;
        if (psum_valid && last_pass) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        m_axis_tvalid = 1'b1;
        if (m_axis_tready && last_beat) begin
          state_nx = S_IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      npass    <= 8'd1;
      pass_cnt <= 8'd0;
      bin_q    <= 1'b0;
      thr_q    <= '0;
      beat_idx <= '0;
      done     <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= done_nx;
      if (clear) begin
        // A zero pass count still consumes exactly one vector.
        npass    <= (num_passes == 8'd0) ? 8'd1 : num_passes;
        bin_q    <= binarize;
        thr_q    <= threshold;
        pass_cnt <= 8'd0;
      end
      if (accept) begin
        pass_cnt <= pass_cnt + 8'd1;
        if (last_pass) beat_idx <= '0;
      end
      if (beat_hs) beat_idx <= last_beat ? '0 : beat_idx + BEAT_W'(1);
    end
  end

  for (genvar i = 0; i < MAC_NUM; i++) begin : g_lane
    logic [ACC_W:0] sum;
    assign sum = {1'b0, acc[i]}
               + {{(ACC_W + 1 - PSUM_W){1'b0}}, psum_in[i*PSUM_W +: PSUM_W]};
    assign acc_sat[i] = sum[ACC_W] ? ACC_MAX : sum[ACC_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < MAC_NUM; i++) acc[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < MAC_NUM; i++) acc[i] <= acc_sat[i];
    end
  end

  // Beat data is a pure mux of stable accumulators, so it holds while stalled.
  always_comb begin
    m_axis_tdata = '0;
    lane         = '0;
    if (state == S_DRAIN) begin
      for (int k = 0; k < BEAT_LANES; k++) begin
        lane = LANE_W'(int'(beat_idx) * BEAT_LANES + k);
        if (bin_q) m_axis_tdata[k] = (acc[lane] >= thr_q);
        else       m_axis_tdata[k*ACC_W +: ACC_W] = acc[lane];
      end
    end
  end

endmodule

// File: tb/tb_psum_collector.sv
// Directed bench for psum_collector: reset abort, raw and binarized tiles,
// saturation, backpressure and start/valid flow rules.
module tb_psum_collector;

  localparam int MAC_NUM    = 256;
  localparam int PSUM_W     = 6;
  localparam int ACC_W      = 12;
  localparam int BEAT_LANES = 32;
  localparam int NBEATS     = MAC_NUM / BEAT_LANES;
  localparam int PW         = PSUM_W * MAC_NUM;
  localparam int TD         = ACC_W * BEAT_LANES;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    num_passes;
  logic          binarize;
  logic [ACC_W-1:0] threshold;
  logic [PW-1:0] psum_in;
  logic          psum_valid;
  logic          psum_ready;
  logic [TD-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  logic [TD-1:0] got_data[$];
  logic          got_last[$];
  int            stall_bad;
  logic          timed_out;
  logic          done_after, done_after2, busy_after;

  always #5 clk = ~clk;

  psum_collector #(
    .MAC_NUM(MAC_NUM), .PSUM_W(PSUM_W), .ACC_W(ACC_W), .BEAT_LANES(BEAT_LANES)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_passes(num_passes),
    .binarize(binarize), .threshold(threshold), .psum_in(psum_in),
    .psum_valid(psum_valid), .psum_ready(psum_ready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .busy(busy), .done(done)
  );

  function automatic logic [PW-1:0] vec_all(input int v);
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < MAC_NUM; i++) r[i*PSUM_W +: PSUM_W] = PSUM_W'(v);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] np, input logic bin, input logic [ACC_W-1:0] thr);
    num_passes = np;
    binarize   = bin;
    threshold  = thr;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic send_vec(input logic [PW-1:0] v);
    psum_in    = v;
    psum_valid = 1'b1;
    tick();
    psum_valid = 1'b0;
  endtask

  // Drains one tile, recording accepted beats and any change of tdata/tlast while stalled.
  task automatic collect(input int ready_pct, input logic start_on_last);
    int            cyc;
    logic          rdy;
    logic          holding;
    logic [TD-1:0] hold_d;
    logic          hold_l;
    got_data.delete();
    got_last.delete();
    stall_bad = 0;
    timed_out = 1'b0;
    holding   = 1'b0;
    hold_d    = '0;
    hold_l    = 1'b0;
    cyc       = 0;
    while (1) begin
      if (holding && m_axis_tvalid === 1'b1)
        if (m_axis_tdata !== hold_d || m_axis_tlast !== hold_l) stall_bad++;
      holding = 1'b0;
      if (cyc > 2000) begin
        timed_out = 1'b1;
        break;
      end
      rdy = ($urandom_range(99) < ready_pct);
      m_axis_tready = rdy;
      if (m_axis_tvalid === 1'b1) begin
        if (rdy) begin
          got_data.push_back(m_axis_tdata);
          got_last.push_back(m_axis_tlast);
          if (m_axis_tlast === 1'b1) begin
            start = start_on_last;
            tick();
            start = 1'b0;
            m_axis_tready = 1'b0;
            break;
          end
        end else begin
          holding = 1'b1;
          hold_d  = m_axis_tdata;
          hold_l  = m_axis_tlast;
        end
      end
      tick();
      cyc++;
    end
    done_after = done;
    busy_after = busy;
    tick();
    done_after2 = done;
  endtask

  task automatic test_reset();
    logic seen_valid;
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (psum_ready !== 1'b0) begin errors++; $display("FAIL reset_psum_ready: got %b want 0", psum_ready); end
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
    checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b want 0", m_axis_tlast); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b%b want 00", busy, done); end
    checks++; if (m_axis_tdata !== '0) begin errors++; $display("FAIL reset_tdata: got %h want 0", m_axis_tdata); end
    rst = 1'b0;
    tick();
    // Abort a tile partway through draining.
    do_start(8'd1, 1'b0, 12'd0);
    send_vec(vec_all(5));
    checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL rst_pre_drain: got %b want 1", m_axis_tvalid); end
    m_axis_tready = 1'b1;
    tick();
    m_axis_tready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_mid_tvalid: got %b want 0", m_axis_tvalid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    checks++; if (psum_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_psum_ready: got %b want 0", psum_ready); end
    seen_valid = 1'b0;
    m_axis_tready = 1'b1;
    repeat (4) begin
      if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0) seen_valid = 1'b1;
      tick();
    end
    m_axis_tready = 1'b0;
    checks++; if (seen_valid !== 1'b0) begin errors++; $display("FAIL rst_no_partial_beats: got %b want 0", seen_valid); end
  endtask

  task automatic test_raw();
    logic [TD-1:0] exp;
    do_start(8'd3, 1'b0, 12'd0);
    send_vec(vec_all(25));
    send_vec(vec_all(10));
    checks++; if (psum_ready !== 1'b1) begin errors++; $display("FAIL raw_still_accum: got %b want 1", psum_ready); end
    send_vec(vec_all(5));
    checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL raw_first_tvalid: got %b want 1", m_axis_tvalid); end
    checks++; if (psum_ready !== 1'b0) begin errors++; $display("FAIL raw_ready_drop: got %b want 0", psum_ready); end
    collect(100, 1'b0);
    checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL raw_timeout: got %b want 0", timed_out); end
    checks++; if (got_data.size() != NBEATS) begin errors++; $display("FAIL raw_beats: got %0d want %0d", got_data.size(), NBEATS); end
    exp = '0;
    for (int k = 0; k < BEAT_LANES; k++) exp[k*ACC_W +: ACC_W] = 12'd40;
    for (int b = 0; b < got_data.size(); b++) begin
      checks++; if (got_data[b] !== exp) begin errors++; $display("FAIL raw_data beat %0d: got %h want %h", b, got_data[b], exp); end
      checks++; if (got_last[b] !== (b == NBEATS - 1)) begin errors++; $display("FAIL raw_tlast beat %0d: got %b want %b", b, got_last[b], (b == NBEATS - 1)); end
    end
    checks++; if (done_after !== 1'b1 || done_after2 !== 1'b0) begin errors++; $display("FAIL raw_done_pulse: got %b%b want 10", done_after, done_after2); end
    checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL raw_busy_after: got %b want 0", busy_after); end
  endtask

  task automatic test_binarize();
    logic [PW-1:0] v;
    logic [TD-1:0] exp;
    v = '0;
    for (int i = 0; i < MAC_NUM; i++) v[i*PSUM_W +: PSUM_W] = PSUM_W'(i % 26);
    do_start(8'd1, 1'b1, 12'd20);
    send_vec(v);
    collect(100, 1'b0);
    checks++; if (got_data.size() != NBEATS) begin errors++; $display("FAIL bin_beats: got %0d want %0d", got_data.size(), NBEATS); end
    for (int b = 0; b < got_data.size(); b++) begin
      exp = '0;
      for (int k = 0; k < BEAT_LANES; k++) exp[k] = (((b * BEAT_LANES + k) % 26) >= 20);
      checks++; if (got_data[b] !== exp) begin errors++; $display("FAIL bin_data beat %0d: got %h want %h", b, got_data[b], exp); end
    end
    // Threshold zero: every lane passes, even all-zero accumulators.
    do_start(8'd1, 1'b1, 12'd0);
    send_vec(vec_all(0));
    collect(100, 1'b0);
    exp = '0;
    for (int k = 0; k < BEAT_LANES; k++) exp[k] = 1'b1;
    checks++; if (got_data.size() != NBEATS) begin errors++; $display("FAIL bin_thr0_beats: got %0d want %0d", got_data.size(), NBEATS); end
    for (int b = 0; b < got_data.size(); b++) begin
      checks++; if (got_data[b] !== exp) begin errors++; $display("FAIL bin_thr0 beat %0d: got %h want %h", b, got_data[b], exp); end
    end
  endtask

  task automatic test_saturation();
    logic [TD-1:0] exp;
    do_start(8'd255, 1'b0, 12'd0);
    for (int p = 0; p < 254; p++) send_vec(vec_all(63));
    checks++; if (psum_ready !== 1'b1) begin errors++; $display("FAIL sat_accum_254: got %b want 1", psum_ready); end
    send_vec(vec_all(63));
    checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL sat_drain_255: got %b want 1", m_axis_tvalid); end
    collect(100, 1'b0);
    exp = '0;
    for (int k = 0; k < BEAT_LANES; k++) exp[k*ACC_W +: ACC_W] = 12'd4095;
    checks++; if (got_data.size() != NBEATS) begin errors++; $display("FAIL sat_beats: got %0d want %0d", got_data.size(), NBEATS); end
    for (int b = 0; b < got_data.size(); b++) begin
      checks++; if (got_data[b] !== exp) begin errors++; $display("FAIL sat_data beat %0d: got %h want %h", b, got_data[b], exp); end
    end
    // num_passes = 0 behaves as one pass.
    do_start(8'd0, 1'b0, 12'd0);
    send_vec(vec_all(7));
    checks++; if (m_axis_tvalid !== 1'b1 || psum_ready !== 1'b0) begin errors++; $display("FAIL np0_drain: got tvalid %b ready %b want 1 0", m_axis_tvalid, psum_ready); end
    collect(100, 1'b0);
    exp = '0;
    for (int k = 0; k < BEAT_LANES; k++) exp[k*ACC_W +: ACC_W] = 12'd7;
    checks++; if (got_data.size() != NBEATS) begin errors++; $display("FAIL np0_beats: got %0d want %0d", got_data.size(), NBEATS); end
    for (int b = 0; b < got_data.size(); b++) begin
      checks++; if (got_data[b] !== exp) begin errors++; $display("FAIL np0_data beat %0d: got %h want %h", b, got_data[b], exp); end
    end
  endtask

  task automatic test_backpressure();
    logic [PW-1:0] v1, v2;
    logic [TD-1:0] exp;
    int            lane;
    v1 = '0;
    v2 = '0;
    for (int i = 0; i < MAC_NUM; i++) begin
      v1[i*PSUM_W +: PSUM_W] = PSUM_W'(i % 64);
      v2[i*PSUM_W +: PSUM_W] = PSUM_W'((3 * i) % 64);
    end
    do_start(8'd2, 1'b0, 12'd0);
    send_vec(v1);
    send_vec(v2);
    collect(30, 1'b0);
    checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL bp_timeout: got %b want 0", timed_out); end
    checks++; if (stall_bad != 0) begin errors++; $display("FAIL bp_stall_stable: got %0d changes want 0", stall_bad); end
    checks++; if (got_data.size() != NBEATS) begin errors++; $display("FAIL bp_beats: got %0d want %0d", got_data.size(), NBEATS); end
    for (int b = 0; b < got_data.size(); b++) begin
      exp = '0;
      for (int k = 0; k < BEAT_LANES; k++) begin
        lane = b * BEAT_LANES + k;
        exp[k*ACC_W +: ACC_W] = ACC_W'((lane % 64) + ((3 * lane) % 64));
      end
      checks++; if (got_data[b] !== exp) begin errors++; $display("FAIL bp_data beat %0d: got %h want %h", b, got_data[b], exp); end
      checks++; if (got_last[b] !== (b == NBEATS - 1)) begin errors++; $display("FAIL bp_tlast beat %0d: got %b want %b", b, got_last[b], (b == NBEATS - 1)); end
    end
    checks++; if (done_after !== 1'b1 || done_after2 !== 1'b0) begin errors++; $display("FAIL bp_done_pulse: got %b%b want 10", done_after, done_after2); end
  endtask

  task automatic test_flow();
    logic [TD-1:0] exp;
    psum_in    = vec_all(9);
    psum_valid = 1'b1;
    repeat (3) tick();
    checks++; if (busy !== 1'b0 || psum_ready !== 1'b0 || m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL flow_idle_valid: got busy %b ready %b tvalid %b want 0 0 0", busy, psum_ready, m_axis_tvalid); end
    do_start(8'd2, 1'b0, 12'd0);
    psum_valid = 1'b0;
    repeat (2) tick();
    send_vec(vec_all(1));
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++; if (busy !== 1'b1 || psum_ready !== 1'b1) begin errors++; $display("FAIL flow_gap_accum: got busy %b ready %b want 1 1", busy, psum_ready); end
    send_vec(vec_all(2));
    // Drive valid and a start pulse while draining; neither may take effect.
    psum_in    = vec_all(50);
    psum_valid = 1'b1;
    start      = 1'b1;
    m_axis_tready = 1'b0;
    tick();
    start = 1'b0;
    checks++; if (m_axis_tvalid !== 1'b1 || psum_ready !== 1'b0) begin errors++; $display("FAIL flow_drain_state: got tvalid %b ready %b want 1 0", m_axis_tvalid, psum_ready); end
    collect(100, 1'b1);
    psum_valid = 1'b0;
    exp = '0;
    for (int k = 0; k < BEAT_LANES; k++) exp[k*ACC_W +: ACC_W] = 12'd3;
    checks++; if (got_data.size() != NBEATS) begin errors++; $display("FAIL flow_beats: got %0d want %0d", got_data.size(), NBEATS); end
    for (int b = 0; b < got_data.size(); b++) begin
      checks++; if (got_data[b] !== exp) begin errors++; $display("FAIL flow_data beat %0d: got %h want %h", b, got_data[b], exp); end
    end
    checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL flow_start_on_last: got busy %b want 0", busy_after); end
    checks++; if (done_after !== 1'b1) begin errors++; $display("FAIL flow_done: got %b want 1", done_after); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    num_passes    = 8'd0;
    binarize      = 1'b0;
    threshold     = '0;
    psum_in       = '0;
    psum_valid    = 1'b0;
    m_axis_tready = 1'b0;
    #1;
    test_reset();
    test_raw();
    test_binarize();
    test_saturation();
    test_backpressure();
    test_flow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
